// File: rtl/ds_uart_pkg.sv
// Shared types and constants for the DS2480B receive path.
package ds_uart_pkg;

    localparam int DS_BAUD_9600_CLKS = 5120;
    localparam int DS_UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } ds_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ds_uart_rx_if.sv
// Byte handshake between the UART receiver and the 1-Wire command controller.
interface ds_uart_rx_if;
    import ds_uart_pkg::*;

    logic [DS_UART_DATA_BITS-1:0] rx_data;
    logic                         rx_valid;
    logic                         rx_overrun;
    logic                         rx_frame_err;
    logic                         rx_busy;
    logic                         rx_ack;

    modport master (
        output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/ds_rx_sync.sv
// Two-flop synchronizer for the RXD pin with a registered falling-edge flag
// that is high in the same cycle the synchronized level first reads 0.
module ds_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic sync,
    output logic fall
);
    logic meta_reg;
    logic sync_reg;
    logic fall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            fall_reg <= 1'b0;
        end else begin
            meta_reg <= rxd;
            sync_reg <= meta_reg;
            fall_reg <= sync_reg & ~meta_reg;
        end
    end

    assign sync = sync_reg;
    assign fall = fall_reg;
endmodule

// File: rtl/ds_uart_rx.sv
// 8N1 receiver for the DS2480B RXD line with valid/ack byte handshake.
// Define DS_UART_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit point.
module ds_uart_rx
    import ds_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DS_BAUD_9600_CLKS,
    parameter int CNT_W        = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxd,
    input  logic            enable,
    ds_uart_rx_if.master    rx
);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
`ifdef DS_UART_RX_MAJORITY_EN
    // Decision point sits one clock past mid-bit so the mid+1 sample exists.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2);
`else
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif

    logic rxd_sync;
    logic rxd_fall;
    logic bit_val;

    ds_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .sync  (rxd_sync),
        .fall  (rxd_fall)
    );

`ifdef DS_UART_RX_MAJORITY_EN
    logic hist1_reg;
    logic hist2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist1_reg <= 1'b1;
            hist2_reg <= 1'b1;
        end else begin
            hist1_reg <= rxd_sync;
            hist2_reg <= hist1_reg;
        end
    end

    assign bit_val = maj3(hist2_reg, hist1_reg, rxd_sync);
`else
    assign bit_val = rxd_sync;
`endif

    ds_rx_state_t                 state_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [2:0]                   idx_reg;
    logic [DS_UART_DATA_BITS-1:0] shift_reg;
    logic [DS_UART_DATA_BITS-1:0] data_reg;
    logic                         valid_reg;
    logic                         overrun_reg;
    logic                         ferr_reg;
    logic                         busy_reg;
    logic                         expire;

    assign expire = (cnt_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= 3'd0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            ferr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ferr_reg <= 1'b0;
            if (rx.rx_ack) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
            if (!enable) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rxd_fall) begin
                            cnt_reg   <= HALF_LOAD;
                            state_reg <= START;
                            busy_reg  <= 1'b1;
                        end
                    end
                    START: begin
                        if (!expire) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end else if (!bit_val) begin
                            cnt_reg   <= BIT_LOAD;
                            idx_reg   <= 3'd0;
                            state_reg <= DATA;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (!expire) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end else begin
                            // Shift in at the top so the first (LSB) bit lands in bit 0.
                            shift_reg <= {bit_val, shift_reg[DS_UART_DATA_BITS-1:1]};
                            cnt_reg   <= BIT_LOAD;
                            if (idx_reg == 3'd7) begin
                                state_reg <= STOP;
                            end else begin
                                idx_reg <= idx_reg + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        if (!expire) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end else if (bit_val) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                            if (valid_reg && !rx.rx_ack) begin
                                overrun_reg <= 1'b1;
                            end
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            ferr_reg  <= 1'b1;
                            state_reg <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        // A break or stuck-low line must go high before a new start is accepted.
                        if (rxd_sync) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx.rx_data      = data_reg;
    assign rx.rx_valid     = valid_reg;
    assign rx.rx_overrun   = overrun_reg;
    assign rx.rx_frame_err = ferr_reg;
    assign rx.rx_busy      = busy_reg;
endmodule

// File: tb/tb_ds_uart_rx.sv
// Scoreboard bench for ds_uart_rx: frames are built bit-by-bit on rxd, a line model
// predicts byte and arrival cycle, and a negedge monitor checks each delivered byte.
module tb_ds_uart_rx;
    localparam int C = 16;
    localparam int H = C / 2;
`ifdef DS_UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // rxd driven low at cycle n -> 2 sync flops -> half bit + 9 bits -> valid one clock later
    localparam int LAT = 3 + H + 9 * C + MAJ;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic rxd    = 1'b1;
    logic enable = 1'b1;

    ds_uart_rx_if bus ();

    ds_uart_rx #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .enable (enable),
        .rx     (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned at;
        logic        ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] last_good = 8'h00;
    bit   model_pending = 0;
    bit   model_ovr = 0;
    int   fe_pulses = 0;
    int   fe_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line level at cycle offset o from the start of the frame.
    function automatic logic line_at(input logic [9:0] fr, input int spike, input int o);
        return fr[o / C] ^ (o == spike);
    endfunction

    // Receiver's view of the bit whose mid-point is at offset o.
    function automatic logic sample_at(input logic [9:0] fr, input int spike, input int o);
        logic a, b, c;
        a = line_at(fr, spike, o - 1);
        b = line_at(fr, spike, o);
        c = line_at(fr, spike, o + 1);
        if (MAJ != 0) return (a & b) | (a & c) | (b & c);
        return b;
    endfunction

    logic prev_valid = 1'b0;
    logic prev_ovr   = 1'b0;
    logic prev_fe    = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if ((bus.rx_valid && !prev_valid) || (bus.rx_overrun && !prev_ovr)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %02h at cycle %0d, want none", bus.rx_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", {24'h0, bus.rx_data}, {24'h0, e.data});
                    check("valid_cycle", cyc, e.at);
                    check("rx_overrun", {31'h0, bus.rx_overrun}, {31'h0, e.ovr});
                    $display("byte %02h at cycle %0d overrun=%0b", bus.rx_data, cyc, bus.rx_overrun);
                end
            end
            if (bus.rx_frame_err) begin
                fe_cycles++;
                if (!prev_fe) fe_pulses++;
            end
        end
        prev_valid <= bus.rx_valid;
        prev_ovr   <= bus.rx_overrun;
        prev_fe    <= bus.rx_frame_err;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; counted=0 for frames that will be aborted on purpose.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit counted, input int spike);
        logic [9:0]  fr;
        logic [7:0]  ed;
        int unsigned n;
        exp_t        e;
        fr = {stop_bit, d, 1'b0};
        @(posedge clk);
        #1;
        n = cyc;
        for (int k = 0; k < 8; k++) ed[k] = sample_at(fr, spike, H + (k + 1) * C);
        if (counted && !sample_at(fr, spike, H) && sample_at(fr, spike, H + 9 * C)) begin
            e.data = ed;
            e.at   = n + LAT;
            e.ovr  = model_pending;
            exp_q.push_back(e);
            model_ovr     = model_pending;
            model_pending = 1;
            last_good     = ed;
        end
        for (int i = 0; i < 10 * C; i++) begin
            rxd = line_at(fr, spike, i);
            @(posedge clk);
            #1;
        end
        rxd = stop_bit;
    endtask

    task automatic do_ack;
        bus.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ack = 1'b0;
        check("valid_after_ack", {31'h0, bus.rx_valid}, 32'd0);
        check("overrun_after_ack", {31'h0, bus.rx_overrun}, 32'd0);
        model_pending = 0;
        model_ovr     = 0;
    endtask

    initial begin
        int fe0, fc0, bc;
        logic [7:0] d;
        bus.rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'h0, bus.rx_data}, 32'd0);
        check("reset_valid", {31'h0, bus.rx_valid}, 32'd0);
        check("reset_overrun", {31'h0, bus.rx_overrun}, 32'd0);
        check("reset_ferr", {31'h0, bus.rx_frame_err}, 32'd0);
        check("reset_busy", {31'h0, bus.rx_busy}, 32'd0);
        reset = 1'b0;
        idle(2 * C);

        // Single byte, then ack.
        send_frame(8'hA5, 1'b1, 1, -1);
        check("a5_valid", {31'h0, bus.rx_valid}, 32'd1);
        check("a5_no_ferr", fe_pulses, 32'd0);
        do_ack();
        idle(C);

        // Back-to-back without ack -> overrun.
        send_frame(8'h3C, 1'b1, 1, -1);
        send_frame(8'hC3, 1'b1, 1, -1);
        check("ovr_data", {24'h0, bus.rx_data}, 32'hC3);
        check("ovr_valid", {31'h0, bus.rx_valid}, 32'd1);
        check("ovr_flag", {31'h0, bus.rx_overrun}, 32'd1);
        do_ack();
        idle(C);

        // 4-clock low glitch: false start, busy only for the half-bit wait.
        bc = 0;
        rxd = 1'b0;
        for (int i = 0; i < 3 * C; i++) begin
            if (i == 4) rxd = 1'b1;
            @(posedge clk);
            #1;
            bc += int'(bus.rx_busy);
        end
        check("glitch_busy_cycles", bc, H + MAJ);
        check("glitch_valid", {31'h0, bus.rx_valid}, 32'd0);

        // Framing error followed by a held-low line.
        fe0 = fe_pulses;
        fc0 = fe_cycles;
        send_frame(8'h55, 1'b0, 1, -1);
        idle(40);
        check("break_busy", {31'h0, bus.rx_busy}, 32'd1);
        rxd = 1'b1;
        idle(2 * C);
        check("ferr_pulses", fe_pulses - fe0, 32'd1);
        check("ferr_width", fe_cycles - fc0, 32'd1);
        check("ferr_data_kept", {24'h0, bus.rx_data}, {24'h0, last_good});
        check("ferr_no_valid", {31'h0, bus.rx_valid}, 32'd0);
        send_frame(8'h81, 1'b1, 1, -1);
        do_ack();
        idle(C);

        // Disable mid-frame during bit 4.
        fork
            send_frame(8'hFF, 1'b1, 0, -1);
            begin
                @(posedge clk);
                #1;
                repeat (5 * C + 4) @(posedge clk);
                #1;
                check("busy_before_disable", {31'h0, bus.rx_busy}, 32'd1);
                enable = 1'b0;
                @(posedge clk);
                #1;
                check("busy_after_disable", {31'h0, bus.rx_busy}, 32'd0);
            end
        join
        enable = 1'b1;
        idle(C);
        check("disable_no_valid", {31'h0, bus.rx_valid}, 32'd0);
        send_frame(8'h0F, 1'b1, 1, -1);
        check("reenable_data", {24'h0, bus.rx_data}, 32'h0F);
        do_ack();
        idle(C);

        // Randomized bytes, gaps and ack decisions.
        for (int t = 0; t < 8; t++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1, 1, -1);
            if (model_ovr || $urandom_range(0, 1) == 1) do_ack();
            idle(int'($urandom_range(1, 3 * C)));
        end
        if (model_pending) do_ack();

        // One-clock spike at the middle of bit 2 of 8'h00.
        send_frame(8'h00, 1'b1, 1, H + 3 * C);
        do_ack();
        idle(C);

        // Asynchronous reset mid-frame with a byte still pending.
        send_frame(8'h12, 1'b1, 1, -1);
        check("pre_reset_valid", {31'h0, bus.rx_valid}, 32'd1);
        rxd = 1'b0;
        repeat (C + H + 3) @(posedge clk);
        #1;
        check("pre_reset_busy", {31'h0, bus.rx_busy}, 32'd1);
        #2;
        reset = 1'b1;
        rxd   = 1'b1;
        #1;
        check("rst_data", {24'h0, bus.rx_data}, 32'd0);
        check("rst_valid", {31'h0, bus.rx_valid}, 32'd0);
        check("rst_overrun", {31'h0, bus.rx_overrun}, 32'd0);
        check("rst_ferr", {31'h0, bus.rx_frame_err}, 32'd0);
        check("rst_busy", {31'h0, bus.rx_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_pending = 0;
        model_ovr     = 0;
        idle(2 * C);
        send_frame(8'h5A, 1'b1, 1, -1);
        do_ack();

        idle(2 * C);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ds_uart_rx.md
Name: ds_uart_rx

Overview:
- RS232 receive path from the DS2480B 1-Wire line driver back into the FPGA.
- Pairs with the existing 9600/4800 Hz baud clocking on the transmit side.
- Oversamples the asynchronous RXD pin with the system clock, recovers 8N1 frames and presents bytes through a valid/ack handshake.
- Consumed by the 1-Wire (DS2480B) command controller.

Parameters:
- CLKS_PER_BIT, 5120, system clocks per bit (49.152 MHz / 9600 baud); minimum 8.
- CNT_W, 13, bit-counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock (49.152 MHz).
- reset  in  1  asynchronous, active-high.
- rxd  in  1  raw serial input from DS2480B; idle high; asynchronous to clk.
- enable  in  1  receiver enable; low forces IDLE.
- rx_ack  in  1  consumer acknowledge; clears rx_valid and rx_overrun.
- rx_data  out  8  last good byte, LSB received first.
- rx_valid  out  1  level; byte available until acked.
- rx_overrun  out  1  sticky; good byte completed while rx_valid was high and not acked.
- rx_frame_err  out  1  one-cycle pulse when stop bit is sampled low.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - rx_data = 8'h00; rx_valid, rx_overrun, rx_frame_err, rx_busy = 0.
  - State IDLE; synchronizer flops = 1.
- Synchronizer: rxd goes through 2 flops. Start is the falling edge of the synchronized signal, i.e. a 1→0 transition.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on start edge with enable=1, load counter with CLKS_PER_BIT/2-1 and go to START.
  - START: counter expires at mid-bit and rxd is sampled.
    - Sample 0: reload CLKS_PER_BIT-1, bit index = 0, go to DATA.
    - Sample 1: false start; return to IDLE with no outputs changed.
  - DATA: on each expiry, shift the sample into the shift register MSB-first so the first bit ends in bit 0. After bit index 7, go to STOP.
  - STOP: sample at expiry.
    - Sample 1: on the next cycle rx_data takes the shift register and rx_valid = 1. Go to IDLE.
    - Sample 0: rx_frame_err pulses for 1 cycle, data is discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized rxd = 1, then go to IDLE. This blocks a break or stuck-low line from retriggering.
- Latency: the stop sample falls 9*CLKS_PER_BIT + CLKS_PER_BIT/2 clocks after the synchronized falling edge. rx_valid rises 1 clock later.
- Handshake:
  - rx_ack=1 clears rx_valid and rx_overrun on the next edge.
  - If a good byte completes while rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, rx_overrun is set.
  - Completion in the same cycle as rx_ack: new data loaded, rx_valid stays 1, no overrun.
  - rx_ack with rx_valid=0 has no effect.
- enable=0 in any state: return to IDLE on the next edge and abort the partial frame. rx_data, rx_valid and rx_overrun are retained.
- Counter: down-counter, expiry at 0, with no wrap beyond reload. Bit index is 3 bits and saturates at 7 before STOP.
- Reset mid-frame: immediately returns all outputs and state to reset values.

Optional Feature:
- Macro: DS_UART_RX_MAJORITY_EN.
- Defined:
  - Each bit (start, data, stop) is sampled at mid-1, mid and mid+1 clocks and decided by 2-of-3 majority.
  - The decision is taken at mid+1, so every decision point and rx_valid move 1 clock later than the single-sample timing.
  - False-start and framing checks use the voted value.
- Undefined: single sample at mid-bit; no vote registers.

Decomposition:
- Package ds_uart_pkg:
  - State encoding typedef (IDLE, START, DATA, STOP, WAIT_IDLE).
  - DS_BAUD_9600_CLKS = 5120.
  - DS_UART_DATA_BITS = 8.
- Sub-module ds_rx_sync: 2-flop synchronizer, reset to 1, with a registered falling-edge detect output.

Test Plan (CLKS_PER_BIT=16):
- Send 8'hA5 as 8N1, idle 1 → rx_valid rises 1 clk after the stop sample, rx_data=8'hA5, rx_frame_err never pulses; rx_ack → rx_valid=0 next clk.
- Send 8'h3C then 8'hC3 back-to-back with no ack → rx_data=8'hC3, rx_valid=1, rx_overrun=1; rx_ack clears both.
- Low glitch of 4 clks on idle line → START samples 1, returns to IDLE, rx_valid stays 0, rx_busy high for exactly the half-bit interval.
- Send 8'h55 with stop bit driven 0, then rxd held low 40 clks → one rx_frame_err pulse, rx_data unchanged, no new frame until rxd returns high; next 8'h81 received correctly.
- Deassert enable during bit 4 of 8'hFF → IDLE next clk, rx_busy=0, no rx_valid; re-enable and send 8'h0F → rx_data=8'h0F.
- Assert reset mid-frame after a prior byte 8'h12 is valid → all outputs 0 and rx_data=8'h00 immediately. With DS_UART_RX_MAJORITY_EN, a 1-clk inverted spike at mid of bit 2 of 8'h00 → rx_data=8'h00 and rx_valid is 1 clk later than without the macro.
